// File: rtl/timer_controller_if.sv
// Button/divider inputs and display-side outputs of the lab timer controller.
interface timer_controller_if;
  logic       clk_1hz;
  logic       start;
  logic       stop;
  logic       softrst;
  logic       inc_min;
  logic       inc_sec;
  logic       mode_sw;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       blink;
  logic       running;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output clk_1hz, start, stop, softrst, inc_min, inc_sec, mode_sw,
    input  minutes, seconds, blink, running, alarm, state
  );

  modport slave (
    input  clk_1hz, start, stop, softrst, inc_min, inc_sec, mode_sw,
    output minutes, seconds, blink, running, alarm, state
  );
endinterface

// File: rtl/timer_controller.sv
// Set/run/pause/alarm sequencer for the lab timer: owns the mm:ss registers,
// countdown or count-up stepping on 1 Hz edges, and the display status flags.
module timer_controller #(
  parameter int MAX_MIN    = 59,
  parameter int ALARM_SECS = 10
) (
  input  logic clk,
  input  logic rst,
  timer_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int         AW      = $clog2(ALARM_SECS + 1);
  localparam logic [5:0] MIN_TOP = 6'(MAX_MIN);
  localparam logic [5:0] SEC_TOP = 6'd59;
  localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_SECS - 1);

  state_t        state_q, state_n;
  logic [5:0]    min_q, min_n;
  logic [5:0]    sec_q, sec_n;
  logic          mode_q, mode_n;
  logic [AW-1:0] acnt_q, acnt_n;
  logic          prev_q;
  logic          blink_q, running_q, alarm_q;
  logic          tick;
  logic          zero_time, top_time;

  assign tick      = bus.clk_1hz & ~prev_q;
  assign zero_time = (min_q == 6'd0) && (sec_q == 6'd0);
  assign top_time  = (min_q == MIN_TOP) && (sec_q == SEC_TOP);

  // Strict priority chain: softrst > stop > start > inc > tick. Whichever
  // branch is taken consumes the cycle, so a losing tick is simply dropped.
  always_comb begin
    state_n = state_q;
    min_n   = min_q;
    sec_n   = sec_q;
    mode_n  = mode_q;
    acnt_n  = acnt_q;

    if (bus.softrst) begin
      state_n = IDLE;
      min_n   = 6'd0;
      sec_n   = 6'd0;
    end else if (bus.stop) begin
      case (state_q)
        RUN:   state_n = PAUSE;
        ALARM: begin
          state_n = IDLE;
          min_n   = 6'd0;
          sec_n   = 6'd0;
        end
        default: ;
      endcase
    end else if (bus.start) begin
      case (state_q)
        IDLE: begin
          mode_n = bus.mode_sw;
          // A countdown from 00:00 would alarm instantly; refuse it.
          if (bus.mode_sw || !zero_time) state_n = RUN;
        end
        PAUSE: state_n = RUN;
        ALARM: begin
          state_n = IDLE;
          min_n   = 6'd0;
          sec_n   = 6'd0;
        end
        default: ;
      endcase
    end else if (bus.inc_min || bus.inc_sec) begin
      if (state_q == IDLE) begin
        if (bus.inc_min) min_n = (min_q == MIN_TOP) ? 6'd0 : min_q + 6'd1;
        if (bus.inc_sec) sec_n = (sec_q == SEC_TOP) ? 6'd0 : sec_q + 6'd1;
      end
    end else if (tick) begin
      case (state_q)
        RUN: begin
          if (!mode_q) begin
            if (sec_q != 6'd0) begin
              sec_n = sec_q - 6'd1;
              if (min_q == 6'd0 && sec_q == 6'd1) begin
                state_n = ALARM;
                acnt_n  = '0;
              end
            end else if (min_q != 6'd0) begin
              min_n = min_q - 6'd1;
              sec_n = SEC_TOP;
            end else begin
              state_n = ALARM;
              acnt_n  = '0;
            end
          end else begin
            if (top_time) begin
              state_n = ALARM;
              acnt_n  = '0;
            end else if (sec_q == SEC_TOP) begin
              sec_n = 6'd0;
              min_n = min_q + 6'd1;
            end else begin
              sec_n = sec_q + 6'd1;
            end
          end
        end
        ALARM: begin
          if (acnt_q == ACNT_LAST) begin
            state_n = IDLE;
            min_n   = 6'd0;
            sec_n   = 6'd0;
            acnt_n  = '0;
          end else begin
            acnt_n = acnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      mode_q    <= 1'b0;
      acnt_q    <= '0;
      prev_q    <= 1'b0;
      blink_q   <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      min_q     <= min_n;
      sec_q     <= sec_n;
      mode_q    <= mode_n;
      acnt_q    <= acnt_n;
      prev_q    <= bus.clk_1hz;
      blink_q   <= (state_n == PAUSE) || (state_n == ALARM);
      running_q <= (state_n == RUN);
      alarm_q   <= (state_n == ALARM);
    end
  end

  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.blink   = blink_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed-vector bench for timer_controller: set/wrap, countdown, pause,
// count-up, event arbitration and mid-run reset.
module tb_timer_controller;

  logic clk;
  logic rst;
  logic hz_hold;
  int   checks;
  int   passes;

  localparam logic [5:0] E_START = 6'b000001;
  localparam logic [5:0] E_STOP  = 6'b000010;
  localparam logic [5:0] E_SRST  = 6'b000100;
  localparam logic [5:0] E_IMIN  = 6'b001000;
  localparam logic [5:0] E_ISEC  = 6'b010000;
  localparam logic [5:0] E_HZ    = 6'b100000;

  timer_controller_if bus();

  timer_controller #(.MAX_MIN(59), .ALARM_SECS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // snapshot = {state, minutes, seconds}; flags = {blink, running, alarm}
  function automatic logic [13:0] snap();
    return {bus.state, bus.minutes, bus.seconds};
  endfunction

  function automatic logic [2:0] flags();
    return {bus.blink, bus.running, bus.alarm};
  endfunction

  task automatic cyc(input logic [5:0] ev);
    bus.start   = ev[0];
    bus.stop    = ev[1];
    bus.softrst = ev[2];
    bus.inc_min = ev[3];
    bus.inc_sec = ev[4];
    bus.clk_1hz = ev[5] | hz_hold;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.softrst = 1'b0;
    bus.inc_min = 1'b0;
    bus.inc_sec = 1'b0;
    bus.clk_1hz = hz_hold;
  endtask

  task automatic reps(input logic [5:0] ev, input int n);
    repeat (n) cyc(ev);
  endtask

  task automatic tick();
    cyc(E_HZ);
    cyc(6'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(6'd0);
    cyc(6'd0);
    checks++;
    if (snap() !== {2'd0, 6'd0, 6'd0}) $display("FAIL reset_time got %h exp %h", snap(), {2'd0, 6'd0, 6'd0});
    else passes++;
    checks++;
    if (flags() !== 3'b000) $display("FAIL reset_flags got %b exp %b", flags(), 3'b000);
    else passes++;
    rst = 1'b0;
    cyc(6'd0);
  endtask

  task automatic test_set_wrap();
    reps(E_IMIN, 3);
    reps(E_ISEC, 61);
    checks++;
    if (snap() !== {2'd0, 6'd3, 6'd1}) $display("FAIL set_0301 got %h exp %h", snap(), {2'd0, 6'd3, 6'd1});
    else passes++;
    reps(E_IMIN, 56);
    checks++;
    if (snap() !== {2'd0, 6'd59, 6'd1}) $display("FAIL set_5901 got %h exp %h", snap(), {2'd0, 6'd59, 6'd1});
    else passes++;
    cyc(E_IMIN);
    checks++;
    if (snap() !== {2'd0, 6'd0, 6'd1}) $display("FAIL min_wrap got %h exp %h", snap(), {2'd0, 6'd0, 6'd1});
    else passes++;
    cyc(E_IMIN | E_ISEC);
    checks++;
    if (snap() !== {2'd0, 6'd1, 6'd2}) $display("FAIL inc_both got %h exp %h", snap(), {2'd0, 6'd1, 6'd2});
    else passes++;
    tick();
    cyc(E_STOP);
    checks++;
    if (snap() !== {2'd0, 6'd1, 6'd2}) $display("FAIL idle_tick_stop got %h exp %h", snap(), {2'd0, 6'd1, 6'd2});
    else passes++;
    cyc(E_SRST);
    checks++;
    if (snap() !== {2'd0, 6'd0, 6'd0}) $display("FAIL idle_softrst got %h exp %h", snap(), {2'd0, 6'd0, 6'd0});
    else passes++;
  endtask

  task automatic test_countdown();
    cyc(E_IMIN | E_ISEC);
    cyc(E_ISEC);
    bus.mode_sw = 1'b0;
    cyc(E_START);
    checks++;
    if ({snap(), flags()} !== {2'd1, 6'd1, 6'd2, 3'b010}) $display("FAIL cd_start got %h exp %h", {snap(), flags()}, {2'd1, 6'd1, 6'd2, 3'b010});
    else passes++;
    tick();
    checks++;
    if (snap() !== {2'd1, 6'd1, 6'd1}) $display("FAIL cd_0101 got %h exp %h", snap(), {2'd1, 6'd1, 6'd1});
    else passes++;
    tick();
    tick();
    checks++;
    if (snap() !== {2'd1, 6'd0, 6'd59}) $display("FAIL cd_borrow got %h exp %h", snap(), {2'd1, 6'd0, 6'd59});
    else passes++;
    repeat (58) tick();
    checks++;
    if (snap() !== {2'd1, 6'd0, 6'd1}) $display("FAIL cd_0001 got %h exp %h", snap(), {2'd1, 6'd0, 6'd1});
    else passes++;
    tick();
    checks++;
    if ({snap(), flags()} !== {2'd3, 6'd0, 6'd0, 3'b101}) $display("FAIL cd_alarm got %h exp %h", {snap(), flags()}, {2'd3, 6'd0, 6'd0, 3'b101});
    else passes++;
    repeat (9) tick();
    checks++;
    if ({snap(), flags()} !== {2'd3, 6'd0, 6'd0, 3'b101}) $display("FAIL cd_alarm9 got %h exp %h", {snap(), flags()}, {2'd3, 6'd0, 6'd0, 3'b101});
    else passes++;
    tick();
    checks++;
    if ({snap(), flags()} !== {2'd0, 6'd0, 6'd0, 3'b000}) $display("FAIL cd_alarm_end got %h exp %h", {snap(), flags()}, {2'd0, 6'd0, 6'd0, 3'b000});
    else passes++;
  endtask

  task automatic test_pause();
    reps(E_ISEC, 31);
    bus.mode_sw = 1'b0;
    cyc(E_START);
    tick();
    cyc(E_STOP);
    checks++;
    if ({snap(), flags()} !== {2'd2, 6'd0, 6'd30, 3'b100}) $display("FAIL pause_enter got %h exp %h", {snap(), flags()}, {2'd2, 6'd0, 6'd30, 3'b100});
    else passes++;
    repeat (5) tick();
    cyc(E_IMIN | E_ISEC);
    checks++;
    if (snap() !== {2'd2, 6'd0, 6'd30}) $display("FAIL pause_hold got %h exp %h", snap(), {2'd2, 6'd0, 6'd30});
    else passes++;
    cyc(E_START);
    checks++;
    if ({snap(), flags()} !== {2'd1, 6'd0, 6'd30, 3'b010}) $display("FAIL resume got %h exp %h", {snap(), flags()}, {2'd1, 6'd0, 6'd30, 3'b010});
    else passes++;
    tick();
    checks++;
    if (snap() !== {2'd1, 6'd0, 6'd29}) $display("FAIL resume_tick got %h exp %h", snap(), {2'd1, 6'd0, 6'd29});
    else passes++;
    repeat (19) tick();
    cyc(E_STOP | E_HZ);
    cyc(6'd0);
    checks++;
    if (snap() !== {2'd2, 6'd0, 6'd10}) $display("FAIL stop_vs_tick got %h exp %h", snap(), {2'd2, 6'd0, 6'd10});
    else passes++;
    cyc(E_SRST);
    checks++;
    if ({snap(), flags()} !== {2'd0, 6'd0, 6'd0, 3'b000}) $display("FAIL pause_softrst got %h exp %h", {snap(), flags()}, {2'd0, 6'd0, 6'd0, 3'b000});
    else passes++;
  endtask

  task automatic test_countup();
    reps(E_ISEC, 58);
    bus.mode_sw = 1'b1;
    cyc(E_START);
    bus.mode_sw = 1'b0;
    tick();
    checks++;
    if (snap() !== {2'd1, 6'd0, 6'd59}) $display("FAIL cu_0059 got %h exp %h", snap(), {2'd1, 6'd0, 6'd59});
    else passes++;
    tick();
    checks++;
    if (snap() !== {2'd1, 6'd1, 6'd0}) $display("FAIL cu_carry got %h exp %h", snap(), {2'd1, 6'd1, 6'd0});
    else passes++;
    cyc(E_SRST);
    reps(E_IMIN, 59);
    reps(E_ISEC, 58);
    bus.mode_sw = 1'b1;
    cyc(E_START);
    bus.mode_sw = 1'b0;
    tick();
    checks++;
    if (snap() !== {2'd1, 6'd59, 6'd59}) $display("FAIL cu_5959 got %h exp %h", snap(), {2'd1, 6'd59, 6'd59});
    else passes++;
    tick();
    checks++;
    if ({snap(), flags()} !== {2'd3, 6'd59, 6'd59, 3'b101}) $display("FAIL cu_saturate got %h exp %h", {snap(), flags()}, {2'd3, 6'd59, 6'd59, 3'b101});
    else passes++;
    cyc(E_START);
    checks++;
    if ({snap(), flags()} !== {2'd0, 6'd0, 6'd0, 3'b000}) $display("FAIL alarm_start got %h exp %h", {snap(), flags()}, {2'd0, 6'd0, 6'd0, 3'b000});
    else passes++;
  endtask

  task automatic test_simultaneous();
    reps(E_ISEC, 5);
    cyc(E_SRST | E_START);
    checks++;
    if (snap() !== {2'd0, 6'd0, 6'd0}) $display("FAIL softrst_start got %h exp %h", snap(), {2'd0, 6'd0, 6'd0});
    else passes++;
    bus.mode_sw = 1'b0;
    cyc(E_START);
    checks++;
    if ({snap(), flags()} !== {2'd0, 6'd0, 6'd0, 3'b000}) $display("FAIL start_zero got %h exp %h", {snap(), flags()}, {2'd0, 6'd0, 6'd0, 3'b000});
    else passes++;
  endtask

  task automatic test_reset_mid();
    reps(E_IMIN, 2);
    reps(E_ISEC, 15);
    bus.mode_sw = 1'b0;
    cyc(E_START);
    checks++;
    if ({snap(), flags()} !== {2'd1, 6'd2, 6'd15, 3'b010}) $display("FAIL mid_run got %h exp %h", {snap(), flags()}, {2'd1, 6'd2, 6'd15, 3'b010});
    else passes++;
    rst     = 1'b1;
    hz_hold = 1'b1;
    cyc(E_START);
    rst = 1'b0;
    checks++;
    if ({snap(), flags()} !== {2'd0, 6'd0, 6'd0, 3'b000}) $display("FAIL mid_reset got %h exp %h", {snap(), flags()}, {2'd0, 6'd0, 6'd0, 3'b000});
    else passes++;
    cyc(6'd0);
    cyc(6'd0);
    reps(E_ISEC, 3);
    cyc(E_START);
    repeat (4) cyc(6'd0);
    checks++;
    if (snap() !== {2'd1, 6'd0, 6'd3}) $display("FAIL hz_high_no_tick got %h exp %h", snap(), {2'd1, 6'd0, 6'd3});
    else passes++;
    hz_hold = 1'b0;
    cyc(6'd0);
    tick();
    checks++;
    if (snap() !== {2'd1, 6'd0, 6'd2}) $display("FAIL hz_next_edge got %h exp %h", snap(), {2'd1, 6'd0, 6'd2});
    else passes++;
    cyc(E_SRST);
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    hz_hold     = 1'b0;
    rst         = 1'b1;
    bus.clk_1hz = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.softrst = 1'b0;
    bus.inc_min = 1'b0;
    bus.inc_sec = 1'b0;
    bus.mode_sw = 1'b0;
    test_reset();
    test_set_wrap();
    test_countdown();
    test_pause();
    test_countup();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
